// File: rtl/accumulator_control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Owns PC/IR/MBR/ACC, drives single-port memory and the shared ALU as Moore decodes of state.
module accumulator_control_fsm #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMM_W    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] acc,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_FETCH        = 3'd0,
        S_FETCH_WAIT   = 3'd1,
        S_DECODE       = 3'd2,
        S_OPERAND_WAIT = 3'd3,
        S_EXECUTE      = 3'd4,
        S_HALTED       = 3'd5
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_LOADI = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_SHR   = 4'hC;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, r_acc, r_ir, r_mbr;
    logic        r_halted, r_illegal;
    logic [15:0] w_pc_nxt, w_acc_nxt, w_ir_nxt, w_mbr_nxt;
    logic        w_halted_nxt, w_illegal_nxt;
    logic [3:0]  w_opcode;
    logic [15:0] w_imm;
    logic [3:0]  w_alu_code;

    assign w_opcode = r_ir[15:12];
    assign w_imm    = {{(16-IMM_W){1'b0}}, r_ir[IMM_W-1:0]};

    // Instruction opcode to shared-ALU function code.
    always_comb begin
        w_alu_code = 4'b0000;
        case (w_opcode)
            OP_SUB:  w_alu_code = 4'b0001;
            OP_SHL:  w_alu_code = 4'b0100;
            OP_SHR:  w_alu_code = 4'b0101;
            OP_AND:  w_alu_code = 4'b1000;
            OP_OR:   w_alu_code = 4'b1001;
            OP_XOR:  w_alu_code = 4'b1010;
            default: w_alu_code = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_acc     <= 16'h0000;
            r_ir      <= 16'h0000;
            r_mbr     <= 16'h0000;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_acc     <= w_acc_nxt;
            r_ir      <= w_ir_nxt;
            r_mbr     <= w_mbr_nxt;
            r_halted  <= w_halted_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_acc_nxt     = r_acc;
        w_ir_nxt      = r_ir;
        w_mbr_nxt     = r_mbr;
        w_halted_nxt  = r_halted;
        w_illegal_nxt = r_illegal;
        mem_addr      = r_pc;
        mem_wdata     = r_acc;
        mem_we        = 1'b0;
        alu_op        = 4'b0000;
        alu_a         = r_acc;
        alu_b         = r_mbr;
        case (r_state)
            S_FETCH: begin
                if (run) w_state_nxt = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                w_ir_nxt    = mem_rdata;
                w_pc_nxt    = r_pc + 16'd1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = S_FETCH;
                case (w_opcode)
                    OP_HALT: begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALTED;
                    end
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        mem_addr    = w_imm;
                        w_state_nxt = S_OPERAND_WAIT;
                    end
                    OP_STORE: begin
                        mem_addr = w_imm;
                        mem_we   = 1'b1;
                    end
                    OP_JUMP:  w_pc_nxt = w_imm;
                    OP_JZ:    if (r_acc == 16'h0000) w_pc_nxt = w_imm;
                    OP_LOADI: w_acc_nxt = w_imm;
                    OP_SHL, OP_SHR: begin
                        alu_op    = w_alu_code;
                        w_acc_nxt = alu_result;
                    end
                    default: begin
                        w_halted_nxt  = 1'b1;
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = S_HALTED;
                    end
                endcase
            end
            S_OPERAND_WAIT: begin
                w_mbr_nxt   = mem_rdata;
                w_state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (w_opcode == OP_LOAD) begin
                    w_acc_nxt = r_mbr;
                end else begin
                    alu_op    = w_alu_code;
                    w_acc_nxt = alu_result;
                end
                w_state_nxt = S_FETCH;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    assign acc     = r_acc;
    assign pc      = r_pc;
    assign ir      = r_ir;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign o_state = r_state;

endmodule

// File: tb/tb_accumulator_control_fsm.sv
// Bench for accumulator_control_fsm: directed ISA scenarios plus random programs
// compared against an instruction-level interpreter.
module tb_accumulator_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [15:0] acc, pc, ir;
    logic        halted, illegal;
    logic [2:0]  st;

    logic        run2 = 1'b0;
    logic [15:0] mem_addr2, mem_wdata2, mem_rdata2;
    logic        mem_we2;
    logic [3:0]  alu_op2;
    logic [15:0] alu_a2, alu_b2;
    logic [15:0] acc2, pc2, ir2;
    logic        halted2, illegal2;
    logic [2:0]  st2;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    accumulator_control_fsm u_dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .acc(acc), .pc(pc), .ir(ir), .halted(halted), .illegal(illegal), .o_state(st)
    );

    accumulator_control_fsm #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .reset(reset), .run(run2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2),
        .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(16'h0000),
        .acc(acc2), .pc(pc2), .ir(ir2), .halted(halted2), .illegal(illegal2), .o_state(st2)
    );

    // Registered-read memory; addresses used by the bench all fit in 512 words.
    logic [15:0] mem [0:511];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[8:0]] = mem_wdata;
        mem_rdata <= mem[mem_addr[8:0]];
    end

    // Wrap instance only ever sees LOADI 0 at 0xFFFF and HALT elsewhere.
    always @(posedge clk) mem_rdata2 <= (mem_addr2 == 16'hFFFF) ? 16'hA000 : 16'h0000;

    always_comb begin
        alu_result = 16'h0000;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a << 1;
            4'b0101: alu_result = alu_a >> 1;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_a ^ alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0;
        run2 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Interpreter state and its own copy of memory.
    logic [15:0] mm [0:511];
    logic [15:0] m_pc, m_acc;
    logic        m_halt, m_ill;
    int          m_cyc;

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            mem[i] = 16'h0000;
            mm[i]  = 16'h0000;
        end
    endtask

    task automatic put(input int a, input logic [15:0] d);
        mem[a] = d;
        mm[a]  = d;
    endtask

    task automatic model_step();
        logic [15:0] ins, imm, opnd;
        ins  = mm[m_pc[8:0]];
        m_pc = m_pc + 16'd1;
        imm  = {4'h0, ins[11:0]};
        opnd = mm[imm[8:0]];
        m_cyc += 3;
        case (ins[15:12])
            4'h0: m_halt = 1'b1;
            4'h1: begin m_acc = opnd;         m_cyc += 2; end
            4'h2: mm[imm[8:0]] = m_acc;
            4'h3: begin m_acc = m_acc + opnd; m_cyc += 2; end
            4'h4: begin m_acc = m_acc - opnd; m_cyc += 2; end
            4'h5: begin m_acc = m_acc & opnd; m_cyc += 2; end
            4'h6: begin m_acc = m_acc | opnd; m_cyc += 2; end
            4'h7: begin m_acc = m_acc ^ opnd; m_cyc += 2; end
            4'h8: m_pc = imm;
            4'h9: if (m_acc == 16'h0000) m_pc = imm;
            4'hA: m_acc = imm;
            4'hB: m_acc = {m_acc[14:0], 1'b0};
            4'hC: m_acc = {1'b0, m_acc[15:1]};
            default: begin m_halt = 1'b1; m_ill = 1'b1; end
        endcase
    endtask

    logic [15:0] exp_q[$];

    initial begin
        int we_before;
        logic [15:0] op, imm;
        int r;

        // Reset state
        clear_mem();
        do_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_acc", acc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        check("rst_illegal", {15'd0, illegal}, 16'h0000);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_we", {15'd0, mem_we}, 16'h0000);
        check("rst_aluop", {12'd0, alu_op}, 16'h0000);
        check("rst_pc_wrap", pc2, 16'hFFFF);

        // Reset asserted in the DECODE cycle of a STORE
        clear_mem();
        put(0, 16'hA055);
        put(1, 16'h2101);
        do_reset();
        run = 1'b1;
        tick(5);
        check("st_we", {15'd0, mem_we}, 16'h0001);
        check("st_addr", mem_addr, 16'h0101);
        check("st_wdata", mem_wdata, 16'h0055);
        reset = 1'b1;
        #1;
        check("mid_rst_we", {15'd0, mem_we}, 16'h0000);
        check("mid_rst_pc", pc, 16'h0000);
        check("mid_rst_acc", acc, 16'h0000);
        check("mid_rst_halted", {15'd0, halted}, 16'h0000);
        run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_nowrite", mem[9'h101], 16'h0000);

        // Run gating
        tick(5);
        check("gate_pc", pc, 16'h0000);
        check("gate_addr", mem_addr, 16'h0000);

        // LOADI 5; ADD [0x100]=7; STORE [0x101]; HALT
        clear_mem();
        put(0, 16'hA005); put(1, 16'h3100); put(2, 16'h2101); put(3, 16'h0000);
        put(9'h100, 16'h0007);
        do_reset();
        run = 1'b1;
        tick(13);
        check("prog_not_halted_13", {15'd0, halted}, 16'h0000);
        tick(1);
        check("prog_halted_14", {15'd0, halted}, 16'h0001);
        check("prog_acc", acc, 16'h000C);
        check("prog_pc", pc, 16'h0004);
        check("prog_mem", mem[9'h101], 16'h000C);

        // SUB wrap, then SHR and SHL
        clear_mem();
        put(0, 16'hA001); put(1, 16'h4100); put(2, 16'hC000); put(3, 16'hB000);
        put(9'h100, 16'h0002);
        do_reset();
        run = 1'b1;
        tick(8);
        check("sub_wrap", acc, 16'hFFFF);
        tick(3);
        check("shr", acc, 16'h7FFF);
        tick(3);
        check("shl", acc, 16'hFFFE);

        // JZ taken, then not taken
        clear_mem();
        put(0, 16'hA000); put(1, 16'h9010);
        put(16, 16'hA003); put(17, 16'h9010);
        do_reset();
        run = 1'b1;
        tick(6);
        check("jz_taken", pc, 16'h0010);
        tick(6);
        check("jz_not_taken", pc, 16'h0012);

        // Illegal opcode freezes the machine
        clear_mem();
        put(0, 16'hE000);
        do_reset();
        we_before = we_cnt;
        run = 1'b1;
        tick(3);
        check("ill_halted", {15'd0, halted}, 16'h0001);
        check("ill_flag", {15'd0, illegal}, 16'h0001);
        tick(20);
        check("ill_pc_frozen", pc, 16'h0001);
        check("ill_ir", ir, 16'hE000);
        check("ill_addr", mem_addr, 16'h0001);
        check("ill_no_we", we_cnt[15:0], we_before[15:0]);
        run = 1'b0;

        // PC wrap from 0xFFFF
        do_reset();
        tick(4);
        check("wrap_gate_pc", pc2, 16'hFFFF);
        run2 = 1'b1;
        tick(3);
        run2 = 1'b0;
        check("wrap_pc", pc2, 16'h0000);
        check("wrap_acc", acc2, 16'h0000);
        check("wrap_halted", {15'd0, halted2}, 16'h0000);

        // Random programs against the interpreter
        for (int t = 0; t < 30; t++) begin
            clear_mem();
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3)      op = 16'h0;
                else if (r < 5) op = 16'(13 + $urandom_range(0, 2));
                else            op = 16'($urandom_range(1, 12));
                if (op >= 1 && op <= 7)  imm = 16'(16'h100 + $urandom_range(0, 15));
                else if (op == 8 || op == 9) imm = 16'($urandom_range(0, 63));
                else                     imm = 16'($urandom_range(0, 4095));
                put(i, {op[3:0], imm[11:0]});
            end
            for (int i = 0; i < 16; i++) put(16'h100 + i, 16'($urandom));
            m_pc = 16'h0; m_acc = 16'h0; m_halt = 1'b0; m_ill = 1'b0; m_cyc = 0;
            for (int s = 0; s < 60 && !m_halt; s++) model_step();
            exp_q.push_back(m_acc);
            exp_q.push_back(m_pc);
            exp_q.push_back({15'd0, m_halt});
            exp_q.push_back({15'd0, m_ill});
            for (int i = 0; i < 16; i++) exp_q.push_back(mm[9'h100 + i]);

            do_reset();
            run = 1'b1;
            tick(m_cyc);
            run = 1'b0;
            tick(2);
            check("rnd_acc", acc, exp_q.pop_front());
            check("rnd_pc", pc, exp_q.pop_front());
            check("rnd_halted", {15'd0, halted}, exp_q.pop_front());
            check("rnd_illegal", {15'd0, illegal}, exp_q.pop_front());
            for (int i = 0; i < 16; i++) check("rnd_mem", mem[9'h100 + i], exp_q.pop_front());
            check("rnd_idle_we", {15'd0, mem_we}, 16'h0000);
            check("rnd_idle_addr", mem_addr, m_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
